// File: rtl/jk_register_bank.sv
// WIDTH-bit bank of JK cells with parallel load and up/down count modes.
// Define JKREG_STICKY_EN to add the per-bit sticky change flags (sticky_clr / sticky).

module jk_register_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               WRAP      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
`ifdef JKREG_STICKY_EN
    input  logic             sticky_clr,
    output logic [WIDTH-1:0] sticky,
`endif
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             changed
);

    typedef enum logic [1:0] {
        MODE_JK         = 2'b00,
        MODE_LOAD       = 2'b01,
        MODE_COUNT_UP   = 2'b10,
        MODE_COUNT_DOWN = 2'b11
    } mode_t;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    mode_t            mode_sel;
    logic [WIDTH-1:0] next_q;
    logic             next_tc;

    assign mode_sel = mode_t'(mode);

    // Next-state value of the bank for an enabled edge; tc marks a wrap or saturation.
    always_comb begin
        next_q  = q;
        next_tc = 1'b0;
        case (mode_sel)
            MODE_JK: begin
                next_q = (q & ~k) | (~q & j);
            end
            MODE_LOAD: begin
                next_q = d;
            end
            MODE_COUNT_UP: begin
                if (q == ALL_ONES) begin
                    next_q  = WRAP ? ZERO : ALL_ONES;
                    next_tc = 1'b1;
                end else begin
                    next_q = q + ONE;
                end
            end
            MODE_COUNT_DOWN: begin
                if (q == ZERO) begin
                    next_q  = WRAP ? ALL_ONES : ZERO;
                    next_tc = 1'b1;
                end else begin
                    next_q = q - ONE;
                end
            end
            default: begin
                next_q  = q;
                next_tc = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q       <= RESET_VAL;
            tc      <= 1'b0;
            changed <= 1'b0;
        end else if (en) begin
            q       <= next_q;
            tc      <= next_tc;
            changed <= (next_q != q);
        end else begin
            changed <= 1'b0;
        end
    end

`ifdef JKREG_STICKY_EN
    // A fresh change on the same edge as sticky_clr must survive the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky <= '0;
        end else begin
            sticky <= (sticky_clr ? ZERO : sticky) | (en ? (q ^ next_q) : ZERO);
        end
    end
`endif

endmodule

// File: doc/jk_register_bank.md
Name: jk_register_bank

Overview:
- WIDTH-bit bank of JK cells with per-bit J/K control.
- Adds parallel load and synchronous up/down count modes.
- Generalised successor of the single-bit JK flip-flop.
- Used as a general state/flag register and small counter in control datapaths.

Parameters:
- WIDTH, 8, number of JK cells (legal range 1..32).
- RESET_VAL, 0, value loaded into q on reset; WIDTH bits.
- WRAP, 1: 1 = count modes wrap modulo 2^WIDTH; 0 = saturate at all-ones (up) or zero (down).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset; sampled on clk rising edge.
- en  input  1  cycle enable; 0 = hold all state.
- mode  input  2  00 JK, 01 LOAD, 10 COUNT_UP, 11 COUNT_DOWN.
- j  input  WIDTH  per-bit J (JK mode only).
- k  input  WIDTH  per-bit K (JK mode only).
- d  input  WIDTH  parallel load data (LOAD mode only).
- q  output  WIDTH  register contents.
- tc  output  1  registered terminal-count flag.
- changed  output  1  registered pulse: q changed on the previous edge.

Behaviour:
- All state updates on the rising edge of clk. Synchronous reset, active-high.
- Reset has priority over everything, including en. On reset: q = RESET_VAL, tc = 0, changed = 0, and the sticky register (if built) = 0.
- en = 0: q and tc hold; changed is forced to 0.
- en = 1, mode 00 (JK), evaluated independently for each bit i:
  - {j[i],k[i]} = 00: hold.
  - 10: set to 1.
  - 01: clear to 0.
  - 11: toggle.
- en = 1, mode 01 (LOAD): q <= d. j, k ignored.
- en = 1, mode 10 (COUNT_UP):
  - q < all-ones: q <= q + 1.
  - q = all-ones: WRAP = 1 gives q <= 0; WRAP = 0 holds all-ones.
- en = 1, mode 11 (COUNT_DOWN):
  - q > 0: q <= q - 1.
  - q = 0: WRAP = 1 gives q <= all-ones; WRAP = 0 holds 0.
- Count arithmetic is WIDTH bits, unsigned. No carry out beyond tc.
- tc is updated every enabled edge and holds when en = 0:
  - COUNT_UP: tc = 1 on the edge where q leaves all-ones (wrap), or where q is held at all-ones (saturation).
  - COUNT_DOWN: the same rule applied at 0.
  - Any other mode: tc = 0.
- tc is a one-cycle-aligned registered flag and goes high in the same cycle q shows the wrapped or saturated value.
- changed = 1 for exactly the cycle after an edge where the new q differs from the old q. Otherwise 0.
- Latency: q, tc and changed all reflect inputs sampled one edge earlier. There are no combinational paths from inputs to outputs.
- mode change mid-count takes effect on the next enabled edge; no pipeline state is carried over.
- Reset asserted mid-count overrides the update on that edge. Counting resumes from RESET_VAL once reset deasserts and en = 1.
- WIDTH = 1: COUNT_UP/COUNT_DOWN with WRAP = 1 behave as toggle. tc = 1 on every enabled count edge where q wraps.

Optional Feature:
- Macro: JKREG_STICKY_EN.
- Defined:
  - Adds input sticky_clr (1 bit) and output sticky (WIDTH bits).
  - sticky[i] is set on any enabled edge where q[i] changes value. It stays set until sticky_clr = 1 on an edge.
  - If a change occurs on the same edge as sticky_clr, set wins: sticky[i] = 1.
  - Reset clears sticky.
- Undefined: these ports and their logic do not exist. All other behaviour is identical.

Test Plan:
- Reset/enable: WIDTH = 8, RESET_VAL = 8'hA5. Pulse reset with en = 1 and mode = 10 -> q = A5, tc = 0, changed = 0. Then set en = 0 for 3 cycles -> q stays A5.
- JK mode: from q = 8'h0F, apply j = F0, k = 0F -> q = F0. Then j = k = FF -> q = 0F. Then j = k = 00 -> q holds 0F. changed = 1, 1, 0 on the respective cycles.
- Wrap up: WRAP = 1, LOAD FE, then COUNT_UP for 3 edges -> q = FF, 00, 01. tc = 0, 1, 0.
- Saturate down: WRAP = 0, LOAD 01, then COUNT_DOWN for 3 edges -> q = 00, 00, 00. tc = 0, 1, 1. changed = 1, 0, 0.
- Reset mid-count: counting up at q = 7F, assert reset for one edge -> q = RESET_VAL, tc = 0. Deassert -> counting continues from RESET_VAL + 1.
- Sticky (with JKREG_STICKY_EN): toggle bit 3 via JK -> sticky = 08. Assert sticky_clr on the same edge as a toggle of bit 0 -> sticky = 01. Assert sticky_clr alone -> sticky = 00.
